// File: rtl/tpu_pkg.sv
// -----------------------------------------------------------------------------
// tpu_pkg
// Shared definitions for the tpuv1 input path: default array geometry, the SRAM
// address of weight row 0 (also used by the SRAM loader and tpuv1 top), and the
// input feeder FSM state type.
// Ports: none (package).
// -----------------------------------------------------------------------------
package tpu_pkg;

    localparam int DEFAULT_DATA_W     = 16;
    localparam int DEFAULT_ARRAY_SIZE = 2;
    localparam int DEFAULT_ADDR_W     = 10;

    // Weight rows live at WEIGHT_BASE..WEIGHT_BASE+ARRAY_SIZE-1; activations at 0.
    localparam int WEIGHT_BASE = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        FEED,
        DRAIN,
        DONE
    } feeder_state_t;

endpackage

// File: rtl/tpu_input_feeder_if.sv
// -----------------------------------------------------------------------------
// tpu_input_feeder_if
// Bundles the feeder's control, SRAM read port and systolic-array feed signals.
//   master : the feeder (drives SRAM read strobe/address, weight and feed lanes,
//            busy/done; receives start, data_size and SRAM read data)
//   slave  : the environment (controller, SRAM, PE grid)
// Optional macro TPU_FEEDER_PERF_CNT_EN adds perf_cycles[31:0] (master output).
// -----------------------------------------------------------------------------
interface tpu_input_feeder_if
    import tpu_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int ARRAY_SIZE = DEFAULT_ARRAY_SIZE,
    parameter int ADDR_W     = DEFAULT_ADDR_W
);
    localparam int ROW_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;

    logic                         tpu_start;
    logic [ADDR_W-1:0]            data_size;
    logic                         sram_rd_en;
    logic [ADDR_W-1:0]            sram_addr;
    logic [ARRAY_SIZE*DATA_W-1:0] sram_rd_data;
    logic                         weight_load;
    logic [ROW_W-1:0]             weight_row;
    logic [ARRAY_SIZE*DATA_W-1:0] weight_data;
    logic [ARRAY_SIZE-1:0]        feed_valid;
    logic [ARRAY_SIZE*DATA_W-1:0] feed_data;
    logic                         busy;
    logic                         done;
`ifdef TPU_FEEDER_PERF_CNT_EN
    logic [31:0]                  perf_cycles;
`endif

    modport master (
        input  tpu_start, data_size, sram_rd_data,
        output sram_rd_en, sram_addr, weight_load, weight_row, weight_data,
               feed_valid, feed_data, busy, done
`ifdef TPU_FEEDER_PERF_CNT_EN
        , output perf_cycles
`endif
    );

    modport slave (
        output tpu_start, data_size, sram_rd_data,
        input  sram_rd_en, sram_addr, weight_load, weight_row, weight_data,
               feed_valid, feed_data, busy, done
`ifdef TPU_FEEDER_PERF_CNT_EN
        , input perf_cycles
`endif
    );

endinterface

// File: rtl/skew_delay_line.sv
// -----------------------------------------------------------------------------
// skew_delay_line
// Delays one activation lane by DEPTH cycles, carrying a valid bit alongside.
// DEPTH=0 degenerates to a wire. Invalid samples are forced to zero so the lane
// output is zero whenever it carries no data.
// Ports: clk, reset (sync, active-high), in_valid/in_data, out_valid/out_data.
// -----------------------------------------------------------------------------
module skew_delay_line #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);
    logic [DATA_W-1:0] in_gated;
    assign in_gated = in_valid ? in_data : '0;

    if (DEPTH == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ reset;
        assign out_valid      = in_valid;
        assign out_data       = in_gated;
    end else begin : g_shift
        logic [DEPTH-1:0]  valid_q;
        logic [DATA_W-1:0] data_q [DEPTH];

        always_ff @(posedge clk) begin
            if (reset) begin
                valid_q <= '0;
                // NOTE: the data stages are cleared as well as the valid bits, so a
                // lane never presents a stale value after reset even if valid is ignored.
                for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
            end else begin
                valid_q[0] <= in_valid;
                data_q[0]  <= in_gated;
                for (int i = 1; i < DEPTH; i++) begin
                    valid_q[i] <= valid_q[i-1];
                    data_q[i]  <= data_q[i-1];
                end
            end
        end

        assign out_valid = valid_q[DEPTH-1];
        assign out_data  = data_q[DEPTH-1];
    end

endmodule

// File: rtl/tpu_input_feeder.sv
// -----------------------------------------------------------------------------
// tpu_input_feeder
// On tpu_start, reads ARRAY_SIZE weight rows (from WEIGHT_BASE) and then
// data_size activation rows (from 0) out of the shared SRAM. Weight rows are
// presented unskewed as load pulses; activation rows are presented as a
// diagonal wavefront where lane k lags lane 0 by k cycles.
// Ports: clk, reset (sync, active-high), bus (tpu_input_feeder_if.master):
//   tpu_start/data_size in, sram_rd_en/sram_addr out, sram_rd_data in (1-cycle
//   latency), weight_load/weight_row/weight_data out, feed_valid/feed_data out,
//   busy/done out.
// Optional macro TPU_FEEDER_PERF_CNT_EN adds perf_cycles: busy cycles of the
// last run, cleared on start acceptance and reset, frozen at done.
// -----------------------------------------------------------------------------
module tpu_input_feeder
    import tpu_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int ARRAY_SIZE  = DEFAULT_ARRAY_SIZE,
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int WEIGHT_BASE = tpu_pkg::WEIGHT_BASE
) (
    input logic                clk,
    input logic                reset,
    tpu_input_feeder_if.master bus
);
    // One extra bit so data_size = 2^ADDR_W-1 is counted without wrapping.
    localparam int CNT_W = ADDR_W + 1;
    localparam int ROW_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(ARRAY_SIZE - 1);

    feeder_state_t     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] size_q;
    logic              cnt_last;
    logic              start_ok;
    logic              busy;

    // Tags for the read returning this cycle (SRAM latency is one cycle).
    logic              ret_weight_q;
    logic              ret_feed_q;
    logic [ROW_W-1:0]  ret_row_q;

    assign start_ok = (state_q == IDLE) && bus.tpu_start;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        // NOTE: all clocked state uses non-blocking assignments so every register
        // samples pre-edge values, independent of block ordering.
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches.
        state_d  = state_q;
        cnt_last = 1'b0;
        unique case (state_q)
            IDLE:   if (bus.tpu_start) state_d = LOAD_W;
            LOAD_W: begin
                cnt_last = (cnt_q == LAST_LANE);
                if (cnt_last) state_d = (size_q == '0) ? DRAIN : FEED;
            end
            FEED: begin
                cnt_last = (cnt_q + CNT_W'(1) == {1'b0, size_q});
                if (cnt_last) state_d = DRAIN;
            end
            // ARRAY_SIZE cycles: one for the final read return, ARRAY_SIZE-1
            // for the deepest skew lane to empty.
            DRAIN: begin
                cnt_last = (cnt_q == LAST_LANE);
                if (cnt_last) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        bus.sram_rd_en = 1'b0;
        bus.sram_addr  = '0;
        busy           = 1'b0;
        bus.done       = 1'b0;
        unique case (state_q)
            LOAD_W: begin
                bus.sram_rd_en = 1'b1;
                bus.sram_addr  = ADDR_W'(WEIGHT_BASE) + ADDR_W'(cnt_q);
                busy           = 1'b1;
            end
            FEED: begin
                bus.sram_rd_en = 1'b1;
                bus.sram_addr  = ADDR_W'(cnt_q);
                busy           = 1'b1;
            end
            DRAIN:   busy     = 1'b1;
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    assign bus.busy = busy;

    // ---------------- counters and read-return tags ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            size_q       <= '0;
            ret_weight_q <= 1'b0;
            ret_feed_q   <= 1'b0;
            ret_row_q    <= '0;
        end else begin
            if (state_d != state_q)  cnt_q <= '0;
            else if (state_q != IDLE) cnt_q <= cnt_q + CNT_W'(1);

            if (start_ok) size_q <= bus.data_size;

            ret_weight_q <= (state_q == LOAD_W);
            ret_feed_q   <= (state_q == FEED);
            ret_row_q    <= (state_q == LOAD_W) ? ROW_W'(cnt_q) : '0;
        end
    end

    assign bus.weight_load = ret_weight_q;
    assign bus.weight_row  = ret_row_q;
    assign bus.weight_data = ret_weight_q ? bus.sram_rd_data : '0;

    // ---------------- skewed activation lanes ----------------
    logic [ARRAY_SIZE-1:0]        lane_valid;
    logic [ARRAY_SIZE*DATA_W-1:0] lane_data;

    for (genvar k = 0; k < ARRAY_SIZE; k++) begin : g_lane
        skew_delay_line #(
            .DATA_W (DATA_W),
            .DEPTH  (k)
        ) u_skew (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (ret_feed_q),
            .in_data   (bus.sram_rd_data[k*DATA_W +: DATA_W]),
            .out_valid (lane_valid[k]),
            .out_data  (lane_data[k*DATA_W +: DATA_W])
        );
    end

    assign bus.feed_valid = lane_valid;
    assign bus.feed_data  = lane_data;

`ifdef TPU_FEEDER_PERF_CNT_EN
    logic [31:0] perf_q;

    // busy is low in DONE and IDLE, so the count freezes at done by itself.
    always_ff @(posedge clk) begin
        if (reset)         perf_q <= '0;
        else if (start_ok) perf_q <= '0;
        else if (busy)     perf_q <= perf_q + 32'd1;
    end

    assign bus.perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_tpu_input_feeder.sv
// -----------------------------------------------------------------------------
// tb_tpu_input_feeder
// Self-checking bench for tpu_input_feeder. An SRAM model answers reads one
// cycle later (random junk otherwise); expected outputs per cycle are derived
// from the run's start offset with plain arithmetic over the SRAM contents.
// Honours TPU_FEEDER_PERF_CNT_EN when defined.
// -----------------------------------------------------------------------------
module tb_tpu_input_feeder;
    import tpu_pkg::*;

    localparam int DW  = 16;
    localparam int A   = 2;
    localparam int AW  = 10;
    localparam int WB  = tpu_pkg::WEIGHT_BASE;
    localparam int ROW = A * DW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tpu_input_feeder_if #(.DATA_W(DW), .ARRAY_SIZE(A), .ADDR_W(AW)) bus ();

    tpu_input_feeder #(
        .DATA_W(DW), .ARRAY_SIZE(A), .ADDR_W(AW), .WEIGHT_BASE(WB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    logic [ROW-1:0] mem [1 << AW];

    // SRAM model: data valid exactly one cycle after a read strobe, junk otherwise.
    always @(posedge clk)
        bus.sram_rd_data <= bus.sram_rd_en ? mem[bus.sram_addr] : ROW'($urandom);

    int n_checks = 0;
    int n_pass   = 0;
    int last_busy = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic expect_zero(input string tag);
        check({tag, ".rd_en"},       64'(bus.sram_rd_en),  64'(0));
        check({tag, ".addr"},        64'(bus.sram_addr),   64'(0));
        check({tag, ".weight_load"}, 64'(bus.weight_load), 64'(0));
        check({tag, ".weight_row"},  64'(bus.weight_row),  64'(0));
        check({tag, ".weight_data"}, 64'(bus.weight_data), 64'(0));
        check({tag, ".feed_valid"},  64'(bus.feed_valid),  64'(0));
        check({tag, ".feed_data"},   64'(bus.feed_data),   64'(0));
        check({tag, ".busy"},        64'(bus.busy),        64'(0));
        check({tag, ".done"},        64'(bus.done),        64'(0));
`ifdef TPU_FEEDER_PERF_CNT_EN
        check({tag, ".perf"},        64'(bus.perf_cycles), 64'(0));
`endif
    endtask

    // Expected outputs at offset o of a run of n rows started at offset 0.
    task automatic expect_at(input int o, input int n);
        int done_off = 2 * A + n + 1;
        int i;
        bit rd, wl, v;
        logic [DW-1:0] lane_exp;
        rd = (o >= 1) && (o <= A + n);
        wl = (o >= 2) && (o <= A + 1);
        check($sformatf("o%0d.rd_en", o), 64'(bus.sram_rd_en), 64'(rd));
        if (rd)
            check($sformatf("o%0d.addr", o), 64'(bus.sram_addr),
                  64'((o <= A) ? (WB + o - 1) : (o - A - 1)));
        check($sformatf("o%0d.weight_load", o), 64'(bus.weight_load), 64'(wl));
        check($sformatf("o%0d.weight_row", o),  64'(bus.weight_row),  64'(wl ? o - 2 : 0));
        check($sformatf("o%0d.weight_data", o), 64'(bus.weight_data),
              wl ? 64'(mem[WB + o - 2]) : 64'(0));
        for (int k = 0; k < A; k++) begin
            i = o - (A + 2) - k;
            v = (i >= 0) && (i < n);
            lane_exp = v ? mem[i][k*DW +: DW] : '0;
            check($sformatf("o%0d.feed_valid[%0d]", o, k), 64'(bus.feed_valid[k]), 64'(v));
            check($sformatf("o%0d.feed_lane%0d", o, k), 64'(bus.feed_data[k*DW +: DW]), 64'(lane_exp));
        end
        check($sformatf("o%0d.busy", o), 64'(bus.busy), 64'((o >= 1) && (o < done_off)));
        check($sformatf("o%0d.done", o), 64'(bus.done), 64'(o == done_off));
`ifdef TPU_FEEDER_PERF_CNT_EN
        if (o >= 1)
            check($sformatf("o%0d.perf", o), 64'(bus.perf_cycles),
                  64'((o - 1 < done_off - 1) ? o - 1 : done_off - 1));
`endif
    endtask

    // One run: start at offset 0; optional stray start pulse at restart_off;
    // optional one-cycle reset at abort_off (then three cycles of all-zero checks).
    task automatic run(input int n, input int restart_off, input int abort_off);
        int done_off = 2 * A + n + 1;
        int last = (abort_off >= 0) ? abort_off + 3 : done_off;
        for (int o = 0; o <= last; o++) begin
            @(negedge clk);
            if (abort_off >= 0 && o > abort_off) expect_zero($sformatf("after_reset.o%0d", o));
            else                                 expect_at(o, n);
            bus.tpu_start = (o == 0) || (o == restart_off);
            bus.data_size = (o == 0) ? AW'(n) : AW'($urandom);
            reset         = (o == abort_off);
        end
        bus.tpu_start = 1'b0;
        reset         = 1'b0;
        last_busy     = (abort_off >= 0) ? 0 : done_off - 1;
    endtask

    task automatic idle(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            check("idle.rd_en",       64'(bus.sram_rd_en),  64'(0));
            check("idle.weight_load", 64'(bus.weight_load), 64'(0));
            check("idle.feed_valid",  64'(bus.feed_valid),  64'(0));
            check("idle.busy",        64'(bus.busy),        64'(0));
            check("idle.done",        64'(bus.done),        64'(0));
`ifdef TPU_FEEDER_PERF_CNT_EN
            check("idle.perf_held",   64'(bus.perf_cycles), 64'(last_busy));
`endif
        end
    endtask

    task automatic load_basic();
        mem[WB]     = 32'h0002_0001;
        mem[WB + 1] = 32'h0004_0003;
        mem[0]      = 32'h0006_0005;
        mem[1]      = 32'h0008_0007;
        mem[2]      = 32'h000A_0009;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < (1 << AW); a++) mem[a] = ROW'($urandom);
        load_basic();
        reset         = 1'b1;
        bus.tpu_start = 1'b0;
        bus.data_size = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        expect_zero("reset");
        reset = 1'b0;
        idle(2);

        // Basic run: weights at 2/3, lane0 5,7 at 4/5, lane1 6,8 at 5/6, done at 7.
        run(2, -1, -1);
        idle(3);

        // Empty activation set: weights only, DRAIN flush, single done.
        run(0, -1, -1);
        idle(3);

        // Start pulse during FEED must be ignored.
        run(2, 4, -1);
        idle(3);

        // Reset after row 0 is read, then a fresh basic run.
        run(2, -1, 4);
        run(2, -1, -1);
        idle(2);

        // Back-to-back: restart in the cycle after done with 3 rows.
        run(2, -1, -1);
        run(3, -1, -1);
        idle(2);

        // Randomised contents and sizes, with a stray start somewhere in FEED.
        for (int r = 0; r < 4; r++) begin
            int n = $urandom_range(1, 12);
            for (int a = 0; a < 32; a++) mem[a] = ROW'($urandom);
            run(n, A + 1 + $urandom_range(0, n - 1), -1);
            idle(1);
        end

        // Largest data_size: the row counter must not wrap.
        for (int a = 0; a < (1 << AW); a++) mem[a] = ROW'($urandom);
        run((1 << AW) - 1, -1, -1);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tpu_input_feeder.md
Name: tpu_input_feeder

Overview:
- Sequencer directly upstream of the systolic array in tpuv1.
- On tpu_start it reads ARRAY_SIZE weight rows, then data_size activation rows, from the shared SRAM.
- Weight rows are presented as load pulses. Activation rows are presented as a diagonally skewed stream: lane k is delayed k cycles, the wavefront the PE grid expects.
- Owns SRAM read-port sequencing; the array consumes every cycle, so there is no backpressure.

Parameters:
- DATA_W, 16, element width in bits
- ARRAY_SIZE, 2, array rows/columns, which is also the lane count
- ADDR_W, 10, SRAM address width
- WEIGHT_BASE, 16, SRAM address of weight row 0; activations start at address 0

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tpu_start  in  1  start pulse; sampled only in IDLE
- data_size  in  ADDR_W  number of activation rows; latched at start
- sram_rd_en  out  1  SRAM read strobe
- sram_addr  out  ADDR_W  SRAM read address
- sram_rd_data  in  ARRAY_SIZE*DATA_W  read data, valid exactly 1 cycle after sram_rd_en; lane k = bits[k*DATA_W +: DATA_W]
- weight_load  out  1  weight_data valid this cycle
- weight_row  out  $clog2(ARRAY_SIZE)  index of the weight row being loaded
- weight_data  out  ARRAY_SIZE*DATA_W  weight row, unskewed
- feed_valid  out  ARRAY_SIZE  per-lane valid for feed_data
- feed_data  out  ARRAY_SIZE*DATA_W  skewed activation lanes
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0; FSM to IDLE; counters and skew registers cleared. Reset has the same effect mid-operation: a read returning after reset is discarded.
- FSM states: IDLE, LOAD_W, FEED, DRAIN, DONE.
- IDLE:
  - tpu_start=1 at edge t latches data_size into size_q and moves to LOAD_W.
  - busy=1 from cycle t+1.
  - tpu_start in any other state is ignored.
- LOAD_W (ARRAY_SIZE cycles):
  - sram_rd_en=1; sram_addr=WEIGHT_BASE+r for r=0..ARRAY_SIZE-1.
  - One cycle later: weight_load=1, weight_row=r, weight_data=sram_rd_data.
  - After the last read, go to FEED, or to DRAIN if size_q==0.
- FEED (size_q cycles):
  - sram_rd_en=1; sram_addr=i for i=0..size_q-1, back-to-back.
  - Returned row i enters skew stage 0.
  - Lane k outputs row i element k with feed_valid[k]=1 at cycle (return cycle of row i)+k.
  - Row counter is ADDR_W+1 bits so data_size=2^ADDR_W-1 does not wrap.
- DRAIN:
  - No reads.
  - Stays until every skew lane is empty. That takes ARRAY_SIZE cycles after the last read, covering the final read return and lane ARRAY_SIZE-1's delay.
  - Then DONE.
- DONE: done=1 for one cycle; busy=0 in the same cycle; next state IDLE.
- Lanes not carrying data drive feed_data lane=0 and feed_valid bit=0.
- Boundary: data_size=0 gives weights loaded, no feed_valid ever, done after DRAIN flush.
- Latency (ARRAY_SIZE=2, start at edge t):
  - weight_load at t+2 and t+3.
  - feed lane0 row0 at t+4; lane1 row0 at t+5.
  - done at the cycle after the last lane1 output.

Optional Feature:
- Macro: TPU_FEEDER_PERF_CNT_EN.
- Defined:
  - Adds output perf_cycles [31:0]: count of cycles with busy=1 in the last run.
  - Cleared on tpu_start acceptance; frozen at done; cleared by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package tpu_pkg holds:
  - FSM state enum feeder_state_t.
  - Default DATA_W/ARRAY_SIZE/ADDR_W.
  - WEIGHT_BASE constant, shared with the SRAM loader and tpuv1.
- Sub-module skew_delay_line, parameters DATA_W and DEPTH.
  - Shift register with valid bit, reset-clearable.
  - Instantiated per lane k with DEPTH=k; DEPTH=0 is a wire.

Test Plan:
- Basic (ARRAY_SIZE=2):
  - SRAM[16]=0x0002_0001, SRAM[17]=0x0004_0003, SRAM[0]=0x0006_0005, SRAM[1]=0x0008_0007, data_size=2, start at t.
  - Expect weight_load at t+2 (row0, data 0x00020001) and t+3 (row1).
  - Expect lane0 = 5 at t+4 and 7 at t+5; lane1 = 6 at t+5 and 8 at t+6.
  - Expect done at t+7.
- data_size=0:
  - Expect two weight_load pulses, no feed_valid, exactly one done.
  - Expect busy to be low after done.
- Start while busy:
  - Pulse tpu_start during FEED.
  - Expect no restart, identical output sequence and a single done.
- Reset mid-FEED:
  - Assert reset for 1 cycle after row 0 has been read.
  - Expect all outputs 0 next cycle, FSM in IDLE, no stale feed_valid.
  - A fresh start then reproduces the basic test.
- Back-to-back runs:
  - Start again in the cycle after done with data_size=3.
  - Expect reads at 16, 17, 0, 1, 2.
- With TPU_FEEDER_PERF_CNT_EN defined, basic test:
  - Expect perf_cycles equal to the busy-cycle count, held after done.
